// File: rtl/ddr_if_pkg.sv
// Shared definitions for the DDR byte receive path: bus widths, default
// word geometry and the word-assembly state encoding.
package ddr_if_pkg;

    localparam int DDR_BYTE_W = 8;
    localparam int PAIR_W     = 2 * DDR_BYTE_W;
    localparam int IQ_PAIRS   = 3;
    localparam int IQ_WORD_W  = 48;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } demux_state_e;

    // Width of an assembled word made of the given number of 16-bit pairs.
    function automatic int word_width(input int pairs);
        return PAIR_W * pairs;
    endfunction

endpackage

// File: rtl/ddr_demux_if.sv
// Bus bundle between the DDR byte pins, the demux and the TX FIFO write port.
// Optional statistics counters appear when DDR_DEMUX_STATS_EN is defined.
interface ddr_demux_if
    import ddr_if_pkg::*;
#(
    parameter int PAIRS = IQ_PAIRS
`ifdef DDR_DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
);

    logic [DDR_BYTE_W-1:0]        in_data;
    logic                         sync;
    logic                         fifo_full;
    logic [word_width(PAIRS)-1:0] out_data;
    logic                         wr_req;
    logic                         overflow;
    logic                         resync;
`ifdef DDR_DEMUX_STATS_EN
    logic [CNT_W-1:0]             words_cnt;
    logic [CNT_W-1:0]             drop_cnt;
    logic [CNT_W-1:0]             resync_cnt;

    modport master (
        output in_data, sync, fifo_full,
        input  out_data, wr_req, overflow, resync,
        input  words_cnt, drop_cnt, resync_cnt
    );

    modport slave (
        input  in_data, sync, fifo_full,
        output out_data, wr_req, overflow, resync,
        output words_cnt, drop_cnt, resync_cnt
    );
`else
    modport master (
        output in_data, sync, fifo_full,
        input  out_data, wr_req, overflow, resync
    );

    modport slave (
        input  in_data, sync, fifo_full,
        output out_data, wr_req, overflow, resync
    );
`endif

endinterface

// File: rtl/ddr_demux_byte_capture.sv
// Double-edge byte capture: the rising edge takes the high byte and the sync
// flag, the falling edge takes the low byte. On the following rising edge the
// completed pair is presented to the word assembler together with its flag.
module ddr_byte_capture
    import ddr_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DDR_BYTE_W-1:0] in_data_i,
    input  logic                  sync_i,
    output logic [PAIR_W-1:0]     pair_o,
    output logic                  pair_sync_o,
    output logic                  pair_valid_o
);

    logic [DDR_BYTE_W-1:0] hi_q;
    logic [DDR_BYTE_W-1:0] lo_q;
    logic                  sync_q;
    logic                  valid_q;

    // Rising edge: high byte and sync; a pair captured during reset is never valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            sync_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            hi_q    <= in_data_i;
            sync_q  <= sync_i;
            valid_q <= 1'b1;
        end
    end

    // Falling edge: low byte of the same clk cycle.
    always_ff @(negedge clk) begin
        if (reset) begin
            lo_q <= '0;
        end else begin
            lo_q <= in_data_i;
        end
    end

    assign pair_o       = {hi_q, lo_q};
    assign pair_sync_o  = sync_q;
    assign pair_valid_o = valid_q;

endmodule

// File: rtl/ddr_demux.sv
// DDR byte bus receiver: reassembles PAIRS x 16-bit pairs (MSB first) into a
// word and writes it to the TX FIFO with a one-cycle strobe. sync acquires
// word alignment; a sync seen mid-word discards the partial word.
// Define DDR_DEMUX_STATS_EN to add saturating words/drop/resync counters.
module ddr_demux
    import ddr_if_pkg::*;
#(
    parameter int PAIRS = IQ_PAIRS
`ifdef DDR_DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
)(
    input  logic        clk,
    input  logic        reset,
    ddr_demux_if.slave  bus
);

    localparam int WORD_W   = word_width(PAIRS);
    localparam int ACC_W    = WORD_W - PAIR_W;
    localparam int CNT_BITS = $clog2(PAIRS);
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(PAIRS - 1);

    logic [PAIR_W-1:0] pair;
    logic              pair_sync;
    logic              pair_valid;

    demux_state_e      state_q,    state_d;
    logic [CNT_BITS-1:0] cnt_q,    cnt_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              wr_req_q,   wr_req_d;
    logic              overflow_q, overflow_d;
    logic              resync_q,   resync_d;

    ddr_byte_capture u_capture (
        .clk          (clk),
        .reset        (reset),
        .in_data_i    (bus.in_data),
        .sync_i       (bus.sync),
        .pair_o       (pair),
        .pair_sync_o  (pair_sync),
        .pair_valid_o (pair_valid)
    );

    // State and output registers; reset drops any partial word and returns to HUNT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            wr_req_q   <= 1'b0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            wr_req_q   <= wr_req_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
        end
    end

    // Word assembly: the accumulator shifts pairs in from the bottom, so once
    // PAIRS-1 pairs are held the arriving pair completes the word MSB-first.
    // Older pairs left over from an aborted word are shifted out naturally.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        wr_req_d   = 1'b0;
        overflow_d = overflow_q;
        resync_d   = 1'b0;

        if (pair_valid) begin
            case (state_q)
                HUNT: begin
                    if (pair_sync) begin
                        state_d = RUN;
                        cnt_d   = CNT_BITS'(1);
                        acc_d   = ACC_W'({acc_q, pair});
                    end
                end
                RUN: begin
                    if (pair_sync) begin
                        resync_d = (cnt_q != '0);
                        cnt_d    = CNT_BITS'(1);
                        acc_d    = ACC_W'({acc_q, pair});
                    end else if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (bus.fifo_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            out_data_d = {acc_q, pair};
                            wr_req_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                        acc_d = ACC_W'({acc_q, pair});
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.wr_req   = wr_req_q;
    assign bus.overflow = overflow_q;
    assign bus.resync   = resync_q;

`ifdef DDR_DEMUX_STATS_EN
    // Events counted in the cycle they are decided so each counter moves
    // together with the pulse it tracks. Index 0 words, 1 drops, 2 resyncs.
    logic [2:0]                  stat_evt;
    logic [2:0][CNT_W-1:0]       stat_vec;

    assign stat_evt[0] = wr_req_d;
    assign stat_evt[1] = pair_valid && (state_q == RUN) && !pair_sync &&
                         (cnt_q == LAST_IDX) && bus.fifo_full;
    assign stat_evt[2] = resync_d;

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [CNT_W-1:0] count_q;

        // Saturating event counter, cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_q <= '0;
            end else if (stat_evt[gi] && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end

        assign stat_vec[gi] = count_q;
    end

    assign bus.words_cnt  = stat_vec[0];
    assign bus.drop_cnt   = stat_vec[1];
    assign bus.resync_cnt = stat_vec[2];
`endif

endmodule
